matmul_pcpi_seq: RTL and testbench
==================================

Name: matmul_pcpi_seq

Overview:
- Parametrised NxN signed matrix-multiply-with-bias coprocessor on the PicoRV32 PCPI bus, custom-0 opcode 7'b0001011.
- CPU loads A, B and bias through PCPI, issues RUN, then reads C = A*B + bias element by element.
- Uses one time-multiplexed MAC instead of a fixed 3x3 array, so N and the data widths scale.
- Adds proper single-shot handshakes and result readback.

Parameters:
- N, 3, matrix dimension (2..8).
- DW, 16, signed element width of A, B and bias.
- ACC_W, 32, signed accumulator and C width (must be >= 2*DW, <= 32).
- IDX_W, derived = clog2(3*N*N), element address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- pcpi_valid  in  1  instruction offered by CPU
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1: element index
- pcpi_rs2  in  32  operand 2: write data
- pcpi_wr  out  1  pcpi_rd is to be written to rd
- pcpi_rd  out  32  result
- pcpi_wait  out  1  busy, CPU must stall
- pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock; reset is synchronous and active-low (resetn sampled on clk rising edge).
  - All outputs 0, FSM IDLE, C array cleared to 0.
  - A, B and bias are not reset.
  - Reset mid-RUN aborts the run on that edge.
- Decode: accept only when pcpi_valid=1, insn[6:0]=0001011 and FSM in IDLE. Unknown funct3 gets no response.
- Address map (idx = rs1[IDX_W-1:0]):
  - A[i][k] at i*N+k.
  - B at N*N + k*N+j.
  - bias at 2*N*N + i*N+j.
- funct3 000 LOAD: store rs2[DW-1:0] at idx.
  - Out-of-range idx is ignored.
  - Next cycle: ready=1, wr=0, rd=0.
- funct3 001 READ: rs1 = i*N+j.
  - Next cycle: ready=1, wr=1, rd = sign-extended C[i][j].
  - idx >= N*N returns rd=0.
- funct3 111 RUN:
  - wait=1 from the cycle after accept until the ready cycle (inclusive of neither edge gap).
  - Ready pulses at accept+N*N*(N+1)+1 with wr=1, rd=N*N*(N+1) (the compute-cycle count).
- FSM states: IDLE, ACK, INIT, MAC, DONE.
  - INIT: acc <= sign-ext bias[i][j], k=0.
  - MAC: N cycles, acc += sext(A[i][k]*B[k][j]).
  - Last MAC cycle writes C[i][j]; then advance j, then i, back to INIT.
  - After (N-1,N-1) go to DONE; DONE asserts ready for one cycle, then ACK.
- LOAD/READ go IDLE -> ACK with ready asserted in ACK.
- ACK lasts exactly one cycle and ignores pcpi_valid. This prevents double execution while the CPU drops valid.
- Arithmetic: DW x DW signed product is full 2*DW, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W, no saturation.
- pcpi_ready is never high for more than one consecutive cycle. wait and ready are never both high.
- A RUN with unloaded operands computes on stale or X contents (no error flag).

Optional Feature:
- MATMUL_THRESH_EN defined:
  - funct3 010 SETTH loads a signed ACC_W threshold from rs2; reset value -70.
  - funct3 011 READB returns rd = {31'b0, C[i][j] >= threshold}, wr=1, same latency as READ.
- Not defined: funct3 010 and 011 are undecoded and get no ready; no threshold register exists.

Decomposition:
- Package matmul_pcpi_pkg holds:
  - OPC_CUSTOM0 = 7'b0001011.
  - funct3 constants F3_LOAD/F3_READ/F3_SETTH/F3_READB/F3_RUN.
  - FSM state enum.
  - THRESH_RST = -70.
- One sub-module, matmul_mac: registered signed multiply-accumulate. Inputs a, b, init value, init/enable; output acc.

Test Plan:
- N=3: load A=I, B=[[1..9]], bias=0, RUN -> ready at accept+37, rd=36, wr=1; READ idx 0..8 returns 1..9.
- A all 2, B all 3, bias[1][2]=-5 -> READ idx 5 returns 13, other elements return 18.
- A[0][0]=-32768, B[0][0]=-32768, rest 0 -> READ 0 returns 0x40000000. Three such terms with ACC_W=32 wrap to 0xC0000000.
- Hold pcpi_valid high 3 cycles during LOAD -> exactly one ready pulse, one write. Non-custom opcode -> no ready, no wait.
- resetn low at cycle 10 of RUN -> next cycle wait=0, ready=0, READ 4 returns 0. A new RUN completes normally.
- MATMUL_THRESH_EN: SETTH rs2=15, C[0][0]=18, C[0][1]=12 -> READB 0 returns 1, READB 1 returns 0. Without the macro, funct3 011 gets no ready.

Source files
------------

// File: rtl/matmul_pcpi_pkg.sv
// rtl/matmul_pcpi_pkg.sv - shared constants and FSM state type for the PCPI matrix-multiply coprocessor
//
// Purpose: opcode and funct3 encodings, threshold reset value and the
// controller state enum used by matmul_pcpi_seq.
// Ports: none (package).

package matmul_pcpi_pkg;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [2:0] F3_LOAD  = 3'b000;
   localparam logic [2:0] F3_READ  = 3'b001;
   localparam logic [2:0] F3_SETTH = 3'b010;
   localparam logic [2:0] F3_READB = 3'b011;
   localparam logic [2:0] F3_RUN   = 3'b111;

   localparam int THRESH_RST = -70;

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      INIT,
      MAC,
      DONE
   } state_t;

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - registered signed multiply-accumulate unit
//
// Purpose: acc <= init_val when init, acc <= acc + sext(a*b) when en.
// Ports:
//   clk, resetn      clock, synchronous active-low reset (clears acc)
//   a, b             signed DW-bit factors
//   init_val         signed ACC_W-bit preload value
//   init, en         preload / accumulate strobes (init has priority)
//   acc              registered accumulator
//   acc_nxt          value acc takes on an accumulate edge

module matmul_mac #(
   parameter int DW    = 16,
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   input  logic signed [ACC_W-1:0] init_val,
   input  logic                    init,
   input  logic                    en,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] acc_nxt
);

   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_ext;

   // Full-width product, sign-extended; the sum wraps modulo 2^ACC_W.
   always_comb begin
      prod     = a * b;
      prod_ext = ACC_W'(prod);
      acc_nxt  = acc + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc <= '0;
      end else if (init) begin
         acc <= init_val;
      end else if (en) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/matmul_pcpi_seq.sv
// rtl/matmul_pcpi_seq.sv - NxN signed matrix multiply-with-bias PCPI coprocessor, one shared MAC
//
// Purpose: CPU loads A, B and bias with LOAD, starts C = A*B + bias with RUN,
// and reads C back with READ. Optional feature macro MATMUL_THRESH_EN adds
// SETTH (threshold register) and READB (C[i][j] >= threshold flag).
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   pcpi_valid           instruction offered by CPU
//   pcpi_insn            instruction word (opcode [6:0], funct3 [14:12])
//   pcpi_rs1             element index
//   pcpi_rs2             write data
//   pcpi_wr              pcpi_rd is to be written to rd
//   pcpi_rd              result
//   pcpi_wait            busy, CPU must stall
//   pcpi_ready           one-cycle completion pulse

module matmul_pcpi_seq
   import matmul_pcpi_pkg::*;
#(
   parameter int N     = 3,
   parameter int DW    = 16,
   parameter int ACC_W = 32,
   parameter int IDX_W = $clog2(3*N*N)
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);

   localparam int NN = N * N;
   localparam int EW = $clog2(NN);
   localparam int CW = $clog2(N);
   localparam logic [IDX_W-1:0] NN_I   = IDX_W'(NN);
   localparam logic [IDX_W-1:0] NN2_I  = IDX_W'(2*NN);
   localparam logic [IDX_W-1:0] NN3_I  = IDX_W'(3*NN);
   localparam logic [CW-1:0]    LAST   = CW'(N-1);
   localparam logic [31:0]      RUN_CY = 32'(NN*(N+1));

   state_t state_q, state_d;

   logic [CW-1:0] i_q, j_q, k_q;
   logic          ack_resp_q;   // ACK came from LOAD/READ (ready) rather than RUN (cool-down only)
   logic          ack_wr_q;
   logic [31:0]   rd_q;

   logic signed [DW-1:0]    a_mem    [NN];
   logic signed [DW-1:0]    b_mem    [NN];
   logic signed [DW-1:0]    bias_mem [NN];
   logic signed [ACC_W-1:0] c_mem    [NN];

   logic [IDX_W-1:0] idx;
   logic [2:0]       f3;
   logic [EW-1:0]    off_b, off_bias;
   logic [EW-1:0]    a_addr, b_addr, c_addr;
   logic             dec_ok, is_read, accept;
   logic signed [ACC_W-1:0] c_rd;
   logic [31:0]             resp_val;
   logic signed [ACC_W-1:0] acc, acc_nxt;

`ifdef MATMUL_THRESH_EN
   logic signed [ACC_W-1:0] thresh_q;
`endif

   logic unused_ok;
   assign unused_ok = ^{pcpi_rs1[31:IDX_W], pcpi_rs2[31:DW],
                        pcpi_insn[31:15], pcpi_insn[11:7], acc};

   assign idx      = pcpi_rs1[IDX_W-1:0];
   assign f3       = pcpi_insn[14:12];
   assign off_b    = EW'(idx - NN_I);
   assign off_bias = EW'(idx - NN2_I);
   assign a_addr   = EW'(int'(i_q) * N + int'(k_q));
   assign b_addr   = EW'(int'(k_q) * N + int'(j_q));
   assign c_addr   = EW'(int'(i_q) * N + int'(j_q));

   always_comb begin
      dec_ok  = 1'b0;
      is_read = 1'b0;
      case (f3)
         F3_LOAD, F3_RUN: dec_ok = 1'b1;
         F3_READ: begin
            dec_ok  = 1'b1;
            is_read = 1'b1;
         end
`ifdef MATMUL_THRESH_EN
         F3_SETTH: dec_ok = 1'b1;
         F3_READB: begin
            dec_ok  = 1'b1;
            is_read = 1'b1;
         end
`endif
         default: dec_ok = 1'b0;
      endcase
   end

   assign accept = pcpi_valid && (pcpi_insn[6:0] == OPC_CUSTOM0) &&
                   (state_q == IDLE) && dec_ok;

   // Readback value, captured at accept and presented during ACK.
   always_comb begin
      c_rd     = c_mem[idx[EW-1:0]];
      resp_val = '0;
      if (f3 == F3_READ && idx < NN_I) begin
         resp_val = 32'(c_rd);
      end
`ifdef MATMUL_THRESH_EN
      if (f3 == F3_READB && idx < NN_I) begin
         resp_val = {31'd0, c_rd >= thresh_q};
      end
`endif
   end

   // Next state and bus outputs.
   always_comb begin
      state_d    = state_q;
      pcpi_wait  = 1'b0;
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (f3 == F3_RUN) ? INIT : ACK;
            end
         end
         ACK: begin
            state_d    = IDLE;
            pcpi_ready = ack_resp_q;
            pcpi_wr    = ack_resp_q && ack_wr_q;
            pcpi_rd    = ack_resp_q ? rd_q : '0;
         end
         INIT: begin
            state_d   = MAC;
            pcpi_wait = 1'b1;
         end
         MAC: begin
            pcpi_wait = 1'b1;
            if (k_q == LAST) begin
               state_d = (i_q == LAST && j_q == LAST) ? DONE : INIT;
            end
         end
         DONE: begin
            state_d    = ACK;
            pcpi_ready = 1'b1;
            pcpi_wr    = 1'b1;
            pcpi_rd    = RUN_CY;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         ack_resp_q <= 1'b0;
         ack_wr_q   <= 1'b0;
         rd_q       <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ack_resp_q <= (f3 != F3_RUN);
            ack_wr_q   <= is_read;
            rd_q       <= resp_val;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
         end
         if (state_q == INIT) begin
            k_q <= '0;
         end else if (state_q == MAC) begin
            if (k_q == LAST) begin
               k_q <= '0;
               if (j_q == LAST) begin
                  j_q <= '0;
                  i_q <= i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

   // Operand storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept && f3 == F3_LOAD) begin
         if (idx < NN_I) begin
            a_mem[idx[EW-1:0]] <= pcpi_rs2[DW-1:0];
         end else if (idx < NN2_I) begin
            b_mem[off_b] <= pcpi_rs2[DW-1:0];
         end else if (idx < NN3_I) begin
            bias_mem[off_bias] <= pcpi_rs2[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int n = 0; n < NN; n++) begin
            c_mem[n] <= '0;
         end
      end else if (state_q == MAC && k_q == LAST) begin
         c_mem[c_addr] <= acc_nxt;
      end
   end

`ifdef MATMUL_THRESH_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         thresh_q <= ACC_W'(THRESH_RST);
      end else if (accept && f3 == F3_SETTH) begin
         thresh_q <= pcpi_rs2[ACC_W-1:0];
      end
   end
`endif

   matmul_mac #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk      (clk),
      .resetn   (resetn),
      .a        (a_mem[a_addr]),
      .b        (b_mem[b_addr]),
      .init_val (ACC_W'(bias_mem[c_addr])),
      .init     (state_q == INIT),
      .en       (state_q == MAC),
      .acc      (acc),
      .acc_nxt  (acc_nxt)
   );

endmodule

// File: tb/tb_matmul_pcpi_seq.sv
// tb/tb_matmul_pcpi_seq.sv - directed self-checking bench for matmul_pcpi_seq (N=3, DW=16, ACC_W=32)

module tb_matmul_pcpi_seq;

   localparam logic [6:0] OPC  = 7'b0001011;
   localparam logic [6:0] OPC_OTHER = 7'b0110011;
   localparam logic [2:0] LD   = 3'b000;
   localparam logic [2:0] RD   = 3'b001;
   localparam logic [2:0] STH  = 3'b010;
   localparam logic [2:0] RDB  = 3'b011;
   localparam logic [2:0] RUN  = 3'b111;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        pcpi_valid = 1'b0;
   logic [31:0] pcpi_insn = '0;
   logic [31:0] pcpi_rs1 = '0;
   logic [31:0] pcpi_rs2 = '0;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   int errors = 0;
   int checks = 0;

   int am [9];
   int bm [9];
   int bsm [9];

   logic        r_got, r_wr, r_bad;
   logic [31:0] r_rd;
   int          r_lat, r_wcnt;

   matmul_pcpi_seq dut (
      .clk        (clk),
      .resetn     (resetn),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_rs1   (pcpi_rs1),
      .pcpi_rs2   (pcpi_rs2),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (pcpi_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
   );

   always #5 clk = ~clk;

   // Bus driver: holds valid through the ready cycle like the CPU does, records
   // latency/wait cycles and flags ready+wait overlap or a second ready cycle.
   task automatic op(input logic [6:0] opc, input logic [2:0] f3,
                     input logic [31:0] a1, input logic [31:0] a2);
      r_got = 0; r_rd = '0; r_wr = 0; r_lat = 0; r_wcnt = 0; r_bad = 0;
      pcpi_insn  = {17'd0, f3, 5'd0, opc};
      pcpi_rs1   = a1;
      pcpi_rs2   = a2;
      pcpi_valid = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (pcpi_ready && pcpi_wait) r_bad = 1;
         if (pcpi_ready) begin
            r_got = 1; r_rd = pcpi_rd; r_wr = pcpi_wr; r_lat = n;
            break;
         end
         if (pcpi_wait) r_wcnt++;
      end
      @(posedge clk); #1;
      if (pcpi_ready || pcpi_wait) r_bad = 1;
      pcpi_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic load_all();
      for (int e = 0; e < 27; e++) begin
         if (e < 9)       op(OPC, LD, e, am[e]);
         else if (e < 18) op(OPC, LD, e, bm[e-9]);
         else             op(OPC, LD, e, bsm[e-18]);
         checks++;
         if (!(r_got && !r_wr && r_rd == 0 && r_lat == 1 && !r_bad))
            $display("FAIL load_resp idx=%0d: got=%0d wr=%0d rd=%h lat=%0d bad=%0d, need got=1 wr=0 rd=0 lat=1 bad=0",
                     e, r_got, r_wr, r_rd, r_lat, r_bad);
         if (!(r_got && !r_wr && r_rd == 0 && r_lat == 1 && !r_bad)) errors++;
      end
   endtask

   task automatic run_check(input string nm);
      op(OPC, RUN, 0, 0);
      checks++;
      if (!(r_got && r_wr && r_rd == 32'd36 && r_lat == 37 && r_wcnt == 36 && !r_bad)) begin
         errors++;
         $display("FAIL %s: got=%0d wr=%0d rd=%0d lat=%0d waitcy=%0d bad=%0d, need 1 1 36 37 36 0",
                  nm, r_got, r_wr, r_rd, r_lat, r_wcnt, r_bad);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b wait=%b wr=%b rd=%h, need all 0",
                  pcpi_ready, pcpi_wait, pcpi_wr, pcpi_rd);
      end
      resetn = 1'b1;
      op(OPC, RD, 0, 0);
      checks++;
      if (!(r_got && r_wr && r_rd === 32'd0 && r_lat == 1)) begin
         errors++;
         $display("FAIL read_after_reset: got=%0d wr=%0d rd=%h lat=%0d, need 1 1 0 1",
                  r_got, r_wr, r_rd, r_lat);
      end
   endtask

   task automatic test_identity();
      for (int e = 0; e < 9; e++) begin
         am[e]  = (e % 4 == 0) ? 1 : 0;
         bm[e]  = e + 1;
         bsm[e] = 0;
      end
      load_all();
      run_check("run_identity");
      for (int e = 0; e < 9; e++) begin
         op(OPC, RD, e, 0);
         checks++;
         if (!(r_got && r_wr && r_rd === 32'(e + 1) && r_lat == 1)) begin
            errors++;
            $display("FAIL identity_read idx=%0d: rd=%0d wr=%0d, need rd=%0d wr=1", e, r_rd, r_wr, e + 1);
         end
      end
   endtask

   task automatic test_bias();
      for (int e = 0; e < 9; e++) begin
         am[e] = 2; bm[e] = 3; bsm[e] = 0;
      end
      bsm[5] = -5;
      load_all();
      run_check("run_bias");
      for (int e = 0; e < 9; e++) begin
         op(OPC, RD, e, 0);
         checks++;
         if (r_rd !== ((e == 5) ? 32'd13 : 32'd18)) begin
            errors++;
            $display("FAIL bias_read idx=%0d: rd=%0d, need %0d", e, r_rd, (e == 5) ? 13 : 18);
         end
      end
   endtask

`ifdef MATMUL_THRESH_EN
   task automatic test_thresh();
      bm[1] = 2; bm[4] = 2; bm[7] = 2;
      load_all();
      run_check("run_thresh");
      op(OPC, RD, 1, 0);
      checks++;
      if (r_rd !== 32'd12) begin
         errors++;
         $display("FAIL thresh_c01: rd=%0d, need 12", r_rd);
      end
      op(OPC, RDB, 1, 0);
      checks++;
      if (!(r_got && r_wr && r_rd === 32'd1 && r_lat == 1)) begin
         errors++;
         $display("FAIL readb_reset_thresh: rd=%0d wr=%0d lat=%0d, need 1 1 1", r_rd, r_wr, r_lat);
      end
      op(OPC, STH, 0, 15);
      checks++;
      if (!(r_got && !r_wr && r_rd === 32'd0 && r_lat == 1)) begin
         errors++;
         $display("FAIL setth_resp: got=%0d wr=%0d rd=%0d, need 1 0 0", r_got, r_wr, r_rd);
      end
      op(OPC, RDB, 0, 0);
      checks++;
      if (r_rd !== 32'd1) begin
         errors++;
         $display("FAIL readb_c00: rd=%0d, need 1", r_rd);
      end
      op(OPC, RDB, 1, 0);
      checks++;
      if (r_rd !== 32'd0) begin
         errors++;
         $display("FAIL readb_c01: rd=%0d, need 0", r_rd);
      end
      op(OPC, RDB, 5, 0);
      checks++;
      if (r_rd !== 32'd0) begin
         errors++;
         $display("FAIL readb_c12: rd=%0d, need 0", r_rd);
      end
   endtask
`else
   task automatic test_undecoded();
      op(OPC, RDB, 0, 0);
      checks++;
      if (r_got || r_wcnt != 0) begin
         errors++;
         $display("FAIL undecoded_f3_011: ready=%0d waitcy=%0d, need 0 0", r_got, r_wcnt);
      end
      op(OPC, STH, 0, 15);
      checks++;
      if (r_got || r_wcnt != 0) begin
         errors++;
         $display("FAIL undecoded_f3_010: ready=%0d waitcy=%0d, need 0 0", r_got, r_wcnt);
      end
   endtask
`endif

   task automatic test_foreign_opcode();
      op(OPC_OTHER, LD, 0, 7);
      checks++;
      if (r_got || r_wcnt != 0 || r_bad) begin
         errors++;
         $display("FAIL foreign_opcode: ready=%0d waitcy=%0d, need 0 0", r_got, r_wcnt);
      end
   endtask

   task automatic test_wrap();
      for (int e = 0; e < 9; e++) begin
         am[e] = 0; bm[e] = 0; bsm[e] = 0;
      end
      am[0] = -32768; bm[0] = -32768;
      load_all();
      run_check("run_single_min");
      op(OPC, RD, 0, 0);
      checks++;
      if (r_rd !== 32'h4000_0000) begin
         errors++;
         $display("FAIL min_square: rd=%h, need 40000000", r_rd);
      end
      op(OPC, RD, 1, 0);
      checks++;
      if (r_rd !== 32'h0) begin
         errors++;
         $display("FAIL min_square_c01: rd=%h, need 0", r_rd);
      end
      am[1] = -32768; am[2] = -32768; bm[3] = -32768; bm[6] = -32768;
      load_all();
      run_check("run_wrap");
      op(OPC, RD, 0, 0);
      checks++;
      if (r_rd !== 32'hC000_0000) begin
         errors++;
         $display("FAIL wrap_sum: rd=%h, need c0000000", r_rd);
      end
      op(OPC, RD, 9, 0);
      checks++;
      if (!(r_got && r_wr && r_rd === 32'd0)) begin
         errors++;
         $display("FAIL read_oob: got=%0d wr=%0d rd=%h, need 1 1 0", r_got, r_wr, r_rd);
      end
      op(OPC, LD, 30, 32'h1234);
      checks++;
      if (!(r_got && !r_wr && r_lat == 1)) begin
         errors++;
         $display("FAIL load_oob: got=%0d wr=%0d lat=%0d, need 1 0 1", r_got, r_wr, r_lat);
      end
   endtask

   task automatic test_reset_mid_run();
      pcpi_insn  = {17'd0, RUN, 5'd0, OPC};
      pcpi_valid = 1'b1;
      @(posedge clk); #1;
      pcpi_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (pcpi_wait !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: wait=%b, need 1", pcpi_wait);
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_abort: wait=%b ready=%b, need 0 0", pcpi_wait, pcpi_ready);
      end
      resetn = 1'b1;
      op(OPC, RD, 4, 0);
      checks++;
      if (!(r_got && r_rd === 32'd0)) begin
         errors++;
         $display("FAIL midrun_c11_cleared: got=%0d rd=%h, need 1 0", r_got, r_rd);
      end
      op(OPC, RD, 0, 0);
      checks++;
      if (r_rd !== 32'd0) begin
         errors++;
         $display("FAIL midrun_c00_cleared: rd=%h, need 0", r_rd);
      end
      run_check("run_after_abort");
      op(OPC, RD, 0, 0);
      checks++;
      if (r_rd !== 32'hC000_0000) begin
         errors++;
         $display("FAIL rerun_c00: rd=%h, need c0000000", r_rd);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_bias();
`ifdef MATMUL_THRESH_EN
      test_thresh();
`else
      test_undecoded();
`endif
      test_foreign_opcode();
      test_wrap();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
